// File: rtl/hs_rr_arbiter.sv
// Purpose: round-robin N:1 handshake arbiter with packet lock; a grant holds from first beat to last.
// Latency: one registered output stage, 1 cycle input-to-output, 1 beat/cycle sustained.
// Backpressure: m_ready low with m_valid high freezes the output stage and forces all s_ready low.
module hs_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int SRC_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            s_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_REQ-1:0]            s_last,
    output logic [NUM_REQ-1:0]            s_ready,
    output logic                          m_valid,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_last,
    output logic [SRC_W-1:0]              m_src,
    input  logic                          m_ready,
    output logic                          busy
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [SRC_W-1:0]      lock_id, lock_id_d;
    logic [SRC_W-1:0]      rr_ptr;
    logic                  win_vld;
    logic [SRC_W-1:0]      win_id;
    logic [DATA_WIDTH-1:0] win_dat;
    logic                  win_last;
    logic                  slot_free;
    logic                  xfer;

    assign slot_free = !m_valid || m_ready;

    // Scan starts just past the last winner so it becomes lowest priority; wrap is modulo NUM_REQ.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        if (state_q == LOCKED) begin
            win_vld = 1'b1;
            win_id  = lock_id;
        end else begin
            for (int off = 1; off <= NUM_REQ; off++) begin
                idx = int'(rr_ptr) + off;
                if (idx >= NUM_REQ)
                    idx = idx - NUM_REQ;
                if (!win_vld && s_valid[idx]) begin
                    win_vld = 1'b1;
                    win_id  = SRC_W'(idx);
                end
            end
        end
    end

    always_comb begin
        win_dat  = s_data[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
        win_last = s_last[win_id];
        xfer     = win_vld && s_valid[win_id] && slot_free;
    end

    always_comb begin
        s_ready = '0;
        for (int i = 0; i < NUM_REQ; i++)
            s_ready[i] = win_vld && (win_id == SRC_W'(i)) && slot_free && rst;
    end

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id;
        case (state_q)
            UNLOCKED: begin
                if (xfer && !win_last) begin
                    state_d   = LOCKED;
                    lock_id_d = win_id;
                end
            end
            LOCKED: begin
                if (xfer && win_last)
                    state_d = UNLOCKED;
            end
            default: state_d = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= UNLOCKED;
            lock_id <= '0;
        end else begin
            state_q <= state_d;
            lock_id <= lock_id_d;
        end
    end

    // A new load and a downstream drain in the same cycle keep m_valid high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_src   <= '0;
            rr_ptr  <= SRC_W'(NUM_REQ - 1);
        end else if (xfer) begin
            m_valid <= 1'b1;
            m_data  <= win_dat;
            m_last  <= win_last;
            m_src   <= win_id;
            rr_ptr  <= win_id;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    assign busy = (state_q == LOCKED);

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed bench for hs_rr_arbiter: a 4-requester instance plus a 3-requester instance for modulo wrap.
module tb_hs_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  s_valid;
    logic [31:0] s_data;
    logic [3:0]  s_last;
    logic [3:0]  s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic [1:0]  m_src;
    logic        m_ready;
    logic        busy;

    logic [2:0]  s3_valid;
    logic [23:0] s3_data;
    logic [2:0]  s3_last;
    logic [2:0]  s3_ready;
    logic        m3_valid;
    logic [7:0]  m3_data;
    logic        m3_last;
    logic [1:0]  m3_src;
    logic        m3_ready;
    logic        busy3;

    int n_cmp = 0;
    int n_bad = 0;

    hs_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_src(m_src),
        .m_ready(m_ready), .busy(busy)
    );

    hs_rr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8)) dut3 (
        .clk(clk), .rst(rst),
        .s_valid(s3_valid), .s_data(s3_data), .s_last(s3_last), .s_ready(s3_ready),
        .m_valid(m3_valid), .m_data(m3_data), .m_last(m3_last), .m_src(m3_src),
        .m_ready(m3_ready), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        s_valid[i]       = v;
        s_data[i*8 +: 8] = d;
        s_last[i]        = l;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                           input logic l, input logic [1:0] src);
        chk({tag, ".m_valid"}, 32'(m_valid), 32'(v));
        chk({tag, ".m_data"},  32'(m_data),  32'(d));
        chk({tag, ".m_last"},  32'(m_last),  32'(l));
        chk({tag, ".m_src"},   32'(m_src),   32'(src));
    endtask

    initial begin
        rst      = 1'b0;
        s_valid  = '0;
        s_data   = '0;
        s_last   = '0;
        m_ready  = 1'b1;
        s3_valid = '0;
        s3_data  = '0;
        s3_last  = '0;
        m3_ready = 1'b1;

        // Reset state; s_ready stays low under reset even with a valid request.
        set_req(0, 1'b1, 8'h01, 1'b1);
        @(negedge clk);
        chk_out("reset", 1'b0, 8'h00, 1'b0, 2'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.s_ready", 32'(s_ready), 32'h0);
        chk("reset.s3_ready", 32'(s3_ready), 32'h0);
        next_edge();
        s_valid = '0;
        rst     = 1'b1;

        // Round-robin: all four hold single-beat packets, order 0,1,2,3,0,1 with no bubble.
        for (int i = 0; i < 4; i++)
            set_req(i, 1'b1, 8'(8'h10 + i), 1'b1);
        @(negedge clk);
        chk("rr.first_ready", 32'(s_ready), 32'b0001);
        for (int k = 0; k < 6; k++) begin
            next_edge();
            if (k == 5)
                s_valid = '0;
            @(negedge clk);
            chk_out($sformatf("rr.beat%0d", k), 1'b1, 8'(8'h10 + (k % 4)), 1'b1, 2'(k % 4));
        end
        next_edge();
        @(negedge clk);
        chk("rr.drain", 32'(m_valid), 32'd0);

        // Single requester 3-beat packet; busy high for the two cycles between first and last beat.
        next_edge();
        set_req(1, 1'b1, 8'hA1, 1'b0);
        @(negedge clk);
        chk("pkt.ready", 32'(s_ready), 32'b0010);
        chk("pkt.busy0", 32'(busy), 32'd0);
        next_edge();
        set_req(1, 1'b1, 8'hA2, 1'b0);
        @(negedge clk);
        chk_out("pkt.A1", 1'b1, 8'hA1, 1'b0, 2'd1);
        chk("pkt.busy1", 32'(busy), 32'd1);
        next_edge();
        set_req(1, 1'b1, 8'hA3, 1'b1);
        @(negedge clk);
        chk_out("pkt.A2", 1'b1, 8'hA2, 1'b0, 2'd1);
        chk("pkt.busy2", 32'(busy), 32'd1);
        next_edge();
        set_req(1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk_out("pkt.A3", 1'b1, 8'hA3, 1'b1, 2'd1);
        chk("pkt.busy3", 32'(busy), 32'd0);
        next_edge();
        @(negedge clk);
        chk_out("pkt.idle_hold", 1'b0, 8'hA3, 1'b1, 2'd1);

        // Lock: req0 arrives during req2's packet and must wait for its last beat.
        next_edge();
        set_req(2, 1'b1, 8'hB0, 1'b0);
        @(negedge clk);
        chk("lock.ready0", 32'(s_ready), 32'b0100);
        next_edge();
        set_req(2, 1'b1, 8'hB1, 1'b0);
        set_req(0, 1'b1, 8'hC0, 1'b1);
        @(negedge clk);
        chk("lock.ready1", 32'(s_ready), 32'b0100);
        chk("lock.busy", 32'(busy), 32'd1);
        chk("lock.B0", 32'(m_data), 32'hB0);
        next_edge();
        set_req(2, 1'b1, 8'hB2, 1'b0);
        @(negedge clk);
        chk("lock.ready2", 32'(s_ready), 32'b0100);
        next_edge();
        set_req(2, 1'b1, 8'hB3, 1'b1);
        @(negedge clk);
        chk("lock.ready3", 32'(s_ready), 32'b0100);
        chk("lock.B2", 32'(m_data), 32'hB2);
        next_edge();
        set_req(2, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk_out("lock.B3", 1'b1, 8'hB3, 1'b1, 2'd2);
        chk("lock.release_ready", 32'(s_ready), 32'b0001);
        chk("lock.unbusy", 32'(busy), 32'd0);
        next_edge();
        set_req(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk_out("lock.C0", 1'b1, 8'hC0, 1'b1, 2'd0);
        next_edge();

        // Backpressure: output frozen for 5 cycles, then drain and reload in the same cycle.
        set_req(1, 1'b1, 8'h55, 1'b1);
        next_edge();
        set_req(1, 1'b0, 8'h00, 1'b0);
        set_req(3, 1'b1, 8'h66, 1'b1);
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_out($sformatf("bp.hold%0d", k), 1'b1, 8'h55, 1'b1, 2'd1);
            chk($sformatf("bp.ready%0d", k), 32'(s_ready), 32'h0);
            next_edge();
        end
        m_ready = 1'b1;
        #1;
        chk("bp.release_ready", 32'(s_ready), 32'b1000);
        next_edge();
        set_req(3, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk_out("bp.next", 1'b1, 8'h66, 1'b1, 2'd3);
        next_edge();

        // Reset mid-packet from req3; afterwards req0 wins over req3.
        set_req(3, 1'b1, 8'hD1, 1'b0);
        next_edge();
        set_req(3, 1'b1, 8'hD2, 1'b0);
        #1;
        chk("rstmid.busy_before", 32'(busy), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk_out("rstmid", 1'b0, 8'h00, 1'b0, 2'd0);
        chk("rstmid.busy", 32'(busy), 32'd0);
        chk("rstmid.s_ready", 32'(s_ready), 32'h0);
        next_edge();
        rst = 1'b1;
        set_req(3, 1'b1, 8'hD1, 1'b1);
        set_req(0, 1'b1, 8'hE0, 1'b1);
        @(negedge clk);
        chk("rstmid.restart_ready", 32'(s_ready), 32'b0001);
        next_edge();
        set_req(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk_out("rstmid.E0", 1'b1, 8'hE0, 1'b1, 2'd0);
        chk("rstmid.next_ready", 32'(s_ready), 32'b1000);
        s_valid = '0;
        next_edge();

        // Three-requester build: 0 and 2 alternate across the modulo-3 wrap.
        s3_valid = 3'b101;
        s3_last  = 3'b101;
        s3_data  = {8'h32, 8'h31, 8'h30};
        @(negedge clk);
        chk("n3.ready", 32'(s3_ready), 32'b001);
        for (int k = 0; k < 4; k++) begin
            next_edge();
            if (k == 3)
                s3_valid = '0;
            @(negedge clk);
            chk($sformatf("n3.src%0d", k), 32'(m3_src), (k % 2 == 0) ? 32'd0 : 32'd2);
            chk($sformatf("n3.data%0d", k), 32'(m3_data), (k % 2 == 0) ? 32'h30 : 32'h32);
            chk($sformatf("n3.valid%0d", k), 32'(m3_valid), 32'd1);
        end
        chk("n3.busy", 32'(busy3), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
